// File: rtl/mem_arb_pkg.sv
// Shared types for the SRAM port arbiter: lock FSM states, index width helper, read-return tag.
package mem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Tag index is fixed-width so the struct can live in the package; covers up to 256 ports.
  localparam int MAX_IDX_W = 8;

  typedef struct packed {
    logic                 valid;
    logic [MAX_IDX_W-1:0] port_idx;
  } rd_tag_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and SRAM-side bundle of the port arbiter; slave = arbiter, master = environment.
interface mem_port_arbiter_if #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic [NUM_PORTS-1:0]              req_i;
  logic [NUM_PORTS-1:0]              lock_i;
  logic [NUM_PORTS-1:0]              we_i;
  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr_i;
  logic [NUM_PORTS*DATA_WIDTH/8-1:0] be_i;
  logic [NUM_PORTS*DATA_WIDTH-1:0]   wdata_i;
  logic [NUM_PORTS-1:0]              gnt_o;
  logic [NUM_PORTS-1:0]              rvalid_o;
  logic [DATA_WIDTH-1:0]             rdata_o;
  logic                              mem_req_o;
  logic                              mem_we_o;
  logic [ADDR_WIDTH-1:0]             mem_addr_o;
  logic [DATA_WIDTH/8-1:0]           mem_be_o;
  logic [DATA_WIDTH-1:0]             mem_data_o;
  logic [DATA_WIDTH-1:0]             mem_data_i;

  modport slave (
    input  req_i, lock_i, we_i, addr_i, be_i, wdata_i, mem_data_i,
    output gnt_o, rvalid_o, rdata_o, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_data_o
  );

  modport master (
    output req_i, lock_i, we_i, addr_i, be_i, wdata_i, mem_data_i,
    input  gnt_o, rvalid_o, rdata_o, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_data_o
  );
endinterface

// File: rtl/mem_arb_rr_picker.sv
// Combinational rotating-priority picker: first set request at or after ptr_i, wrapping to 0.
module mem_arb_rr_picker
  import mem_arb_pkg::*;
#(
  parameter  int NUM_PORTS = 2,
  localparam int IW        = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IW-1:0]        ptr_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [IW-1:0]        idx_o,
  output logic                 any_o
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = ptr_i;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
      // Explicit wrap keeps non-power-of-2 port counts in range.
      cand = (cand == IW'(NUM_PORTS - 1)) ? '0 : cand + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one single-ported SRAM; grant is same-cycle, rvalid follows RD_LATENCY cycles later.
// Optional grant locking for burst masters is compiled in with MEM_ARB_LOCK_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int RD_LATENCY = 1
) (
  input logic             clk_i,
  input logic             rst_i,
  mem_port_arbiter_if.slave bus
);

  localparam int IW = idx_width(NUM_PORTS);
  localparam int BW = DATA_WIDTH / 8;

  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  rd_tag_t              tag_q [RD_LATENCY];
  rd_tag_t              tag_d [RD_LATENCY];
  logic [NUM_PORTS-1:0] req_eff;
  logic [NUM_PORTS-1:0] pick_gnt;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;
  logic                 gnt_vld;

  mem_arb_rr_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
    .req_i (req_eff),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Grants are suppressed while reset is asserted so the SRAM sees no access.
  assign gnt_vld = pick_any & ~rst_i;

`ifdef MEM_ARB_LOCK_EN
  arb_state_t    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic          lock_hold;

  always_comb begin
    lock_hold = (state_q == LOCKED) && bus.lock_i[owner_q];
    req_eff   = bus.req_i;
    if (lock_hold) begin
      req_eff = bus.req_i & (NUM_PORTS'(1) << owner_q);
    end
  end

  always_comb begin
    state_d = IDLE;
    owner_d = owner_q;
    if (gnt_vld && bus.lock_i[pick_idx]) begin
      state_d = LOCKED;
      owner_d = pick_idx;
    end else if (lock_hold) begin
      state_d = LOCKED;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^bus.lock_i;
  assign req_eff     = bus.req_i;
`endif

  always_comb begin
    bus.gnt_o      = gnt_vld ? pick_gnt : '0;
    bus.mem_req_o  = gnt_vld;
    bus.mem_we_o   = gnt_vld & bus.we_i[pick_idx];
    bus.mem_addr_o = gnt_vld ? bus.addr_i[pick_idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    bus.mem_be_o   = gnt_vld ? bus.be_i[pick_idx*BW +: BW] : '0;
    bus.mem_data_o = gnt_vld ? bus.wdata_i[pick_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_vld) begin
      rr_ptr_d = (pick_idx == IW'(NUM_PORTS - 1)) ? '0 : pick_idx + 1'b1;
    end
    tag_d[0].valid    = gnt_vld & ~bus.we_i[pick_idx];
    tag_d[0].port_idx = MAX_IDX_W'(pick_idx);
    for (int i = 1; i < RD_LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Last tag stage lines up with the SRAM's read data, which passes straight through.
  always_comb begin
    bus.rvalid_o = tag_q[RD_LATENCY-1].valid ?
                   (NUM_PORTS'(1) << tag_q[RD_LATENCY-1].port_idx) : '0;
    bus.rdata_o  = bus.mem_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int i = 0; i < RD_LATENCY; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (read latency 1 and 3) share one directed stimulus stream.
module tb_mem_port_arbiter;

  localparam int N  = 2;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req, lock, we;
  logic [AW-1:0] addr_v [N];
  logic [BW-1:0] be_v   [N];
  logic [DW-1:0] wd_v   [N];
  logic [DW-1:0] mem_data;
  int            stamp = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if1 ();
  mem_port_arbiter_if #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if3 ();

  assign if1.req_i      = req;
  assign if1.lock_i     = lock;
  assign if1.we_i       = we;
  assign if1.addr_i     = {addr_v[1], addr_v[0]};
  assign if1.be_i       = {be_v[1], be_v[0]};
  assign if1.wdata_i    = {wd_v[1], wd_v[0]};
  assign if1.mem_data_i = mem_data;
  assign if3.req_i      = req;
  assign if3.lock_i     = lock;
  assign if3.we_i       = we;
  assign if3.addr_i     = {addr_v[1], addr_v[0]};
  assign if3.be_i       = {be_v[1], be_v[0]};
  assign if3.wdata_i    = {wd_v[1], wd_v[0]};
  assign if3.mem_data_i = mem_data;

  mem_port_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) dut1 (
    .clk_i (clk), .rst_i (rst), .bus (if1));
  mem_port_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(3)) dut3 (
    .clk_i (clk), .rst_i (rst), .bus (if3));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            rr = 0;
  int            ncyc = 0;
  int            pend1 [int];
  int            pend3 [int];
  int            g;
  bit            lk;
  logic [N-1:0]  e_gnt, e_rv1, e_rv3;
  logic          e_req, e_we;
  logic [AW-1:0] e_addr;
  logic [BW-1:0] e_be;
  logic [DW-1:0] e_dat;
`ifdef MEM_ARB_LOCK_EN
  bit            locked = 0;
  int            owner = 0;
`endif

  task automatic cmp_inst(input string p, input logic [N-1:0] gnt, input logic mreq, input logic mwe,
                          input logic [AW-1:0] maddr, input logic [BW-1:0] mbe, input logic [DW-1:0] mdat,
                          input logic [N-1:0] rv, input logic [DW-1:0] rd, input logic [N-1:0] erv);
    chk({p, "_gnt"}, 64'(gnt), 64'(e_gnt));
    chk({p, "_mem_req"}, 64'(mreq), 64'(e_req));
    chk({p, "_mem_we"}, 64'(mwe), 64'(e_we));
    chk({p, "_mem_addr"}, maddr, e_addr);
    chk({p, "_mem_be"}, 64'(mbe), 64'(e_be));
    chk({p, "_mem_data"}, mdat, e_dat);
    chk({p, "_rvalid"}, 64'(rv), 64'(erv));
    if (erv != '0) chk({p, "_rdata"}, rd, mem_data);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      ncyc++;
      g  = -1;
      lk = 1'b0;
      if (!rst) begin
`ifdef MEM_ARB_LOCK_EN
        lk = locked && lock[owner];
`endif
        for (int k = 0; k < N; k++) begin
          int p;
          p = (rr + k) % N;
          if (g < 0 && req[p] && (!lk || p == owner_of())) g = p;
        end
      end
      e_gnt  = (g >= 0) ? (N'(1) << g) : '0;
      e_req  = (g >= 0);
      e_we   = (g >= 0) ? we[g] : 1'b0;
      e_addr = (g >= 0) ? addr_v[g] : '0;
      e_be   = (g >= 0) ? be_v[g] : '0;
      e_dat  = (g >= 0) ? wd_v[g] : '0;
      e_rv1  = (!rst && pend1.exists(ncyc)) ? (N'(1) << pend1[ncyc]) : '0;
      e_rv3  = (!rst && pend3.exists(ncyc)) ? (N'(1) << pend3[ncyc]) : '0;
      cmp_inst("l1", if1.gnt_o, if1.mem_req_o, if1.mem_we_o, if1.mem_addr_o, if1.mem_be_o,
               if1.mem_data_o, if1.rvalid_o, if1.rdata_o, e_rv1);
      cmp_inst("l3", if3.gnt_o, if3.mem_req_o, if3.mem_we_o, if3.mem_addr_o, if3.mem_be_o,
               if3.mem_data_o, if3.rvalid_o, if3.rdata_o, e_rv3);
      if (rst) begin
        rr = 0;
        pend1.delete();
        pend3.delete();
`ifdef MEM_ARB_LOCK_EN
        locked = 0;
`endif
      end else begin
        if (g >= 0) begin
          rr = (g + 1) % N;
          if (!we[g]) begin
            pend1[ncyc + 1] = g;
            pend3[ncyc + 3] = g;
          end
        end
`ifdef MEM_ARB_LOCK_EN
        if (g >= 0 && lock[g]) begin
          locked = 1;
          owner  = g;
        end else if (!lk) begin
          locked = 0;
        end
`endif
      end
    end
  end

  function automatic int owner_of();
`ifdef MEM_ARB_LOCK_EN
    return owner;
`else
    return 0;
`endif
  endfunction

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
    stamp++;
    mem_data = {32'hD00D_F00D, 32'(stamp)};
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic drv(input logic [1:0] r, input logic [1:0] l, input logic [1:0] w,
                     input logic [63:0] a0, input logic [63:0] a1);
    req       = r;
    lock      = l;
    we        = w;
    addr_v[0] = a0;
    addr_v[1] = a1;
    be_v[0]   = 8'hFF;
    be_v[1]   = 8'hFF;
    wd_v[0]   = 64'h1111_0000_0000_0000 | a0;
    wd_v[1]   = 64'h2222_0000_0000_0000 | a1;
  endtask

  logic [1:0] t5exp [3];
  logic [1:0] exp_g;

  initial begin
    t5exp = '{2'b01, 2'b10, 2'b01};
    rst      = 1'b1;
    mem_data = '0;
    drv(2'b00, 2'b00, 2'b00, 64'h0, 64'h0);
    repeat (3) @(posedge clk);

    // Reset release, then idle
    next_cycle();
    rst = 1'b0;
    settle();
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      drv(2'b00, 2'b00, 2'b00, 64'h0, 64'h0);
      settle();
      chk("idle_gnt", 64'(if1.gnt_o), 64'h0);
      chk("idle_mem_req", 64'(if1.mem_req_o), 64'h0);
      chk("idle_rvalid", 64'(if1.rvalid_o | if3.rvalid_o), 64'h0);
    end

    // Port0 read of 0x100
    next_cycle();
    drv(2'b01, 2'b00, 2'b00, 64'h100, 64'h0);
    settle();
    chk("rd_gnt", 64'(if1.gnt_o), 64'h1);
    chk("rd_addr", if1.mem_addr_o, 64'h100);
    chk("rd_we", 64'(if1.mem_we_o), 64'h0);

    // Port1 write 0xDEADBEEF @0x40 be 0x0F; read data of the previous cycle returns
    next_cycle();
    drv(2'b10, 2'b00, 2'b10, 64'h0, 64'h40);
    be_v[1] = 8'h0F;
    wd_v[1] = 64'hDEAD_BEEF;
    settle();
    chk("rd_rvalid", 64'(if1.rvalid_o), 64'h1);
    chk("rd_rdata", if1.rdata_o, mem_data);
    chk("wr_gnt", 64'(if1.gnt_o), 64'h2);
    chk("wr_we", 64'(if1.mem_we_o), 64'h1);
    chk("wr_be", 64'(if1.mem_be_o), 64'h0F);
    chk("wr_data", if1.mem_data_o, 64'hDEAD_BEEF);

    // Port0 reads back 0x40
    next_cycle();
    drv(2'b01, 2'b00, 2'b00, 64'h40, 64'h0);
    settle();
    chk("rb_gnt", 64'(if1.gnt_o), 64'h1);
    chk("wr_no_rvalid", 64'(if1.rvalid_o), 64'h0);

    next_cycle();
    drv(2'b00, 2'b00, 2'b00, 64'h0, 64'h0);
    settle();
    chk("rb_rvalid", 64'(if1.rvalid_o), 64'h1);
    chk("lat3_first_rvalid", 64'(if3.rvalid_o), 64'h1);

    // Port1 write moves the pointer back to port0
    next_cycle();
    drv(2'b10, 2'b00, 2'b10, 64'h0, 64'h80);
    settle();
    chk("wr2_gnt", 64'(if1.gnt_o), 64'h2);

    // Both ports reading continuously
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      drv(2'b11, 2'b00, 2'b00, 64'h200 + 64'(i * 8), 64'h300 + 64'(i * 8));
      settle();
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      chk("rr_gnt", 64'(if1.gnt_o), 64'(exp_g));
    end
    repeat (3) begin
      next_cycle();
      drv(2'b00, 2'b00, 2'b00, 64'h0, 64'h0);
      settle();
    end

    // Back-to-back reads p0,p1,p0 with latency 3
    next_cycle(); drv(2'b01, 2'b00, 2'b00, 64'h500, 64'h0); settle();
    next_cycle(); drv(2'b10, 2'b00, 2'b00, 64'h0, 64'h510); settle();
    next_cycle(); drv(2'b01, 2'b00, 2'b00, 64'h520, 64'h0); settle();
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      drv(2'b00, 2'b00, 2'b00, 64'h0, 64'h0);
      settle();
      chk("lat3_order", 64'(if3.rvalid_o), 64'(t5exp[k]));
      chk("lat3_rdata", if3.rdata_o, mem_data);
    end

    // Reset in the middle of an outstanding read
    next_cycle();
    drv(2'b10, 2'b00, 2'b00, 64'h0, 64'h600);
    settle();
    chk("pre_rst_gnt", 64'(if1.gnt_o), 64'h2);
    next_cycle();
    rst = 1'b1;
    drv(2'b00, 2'b00, 2'b00, 64'h0, 64'h0);
    settle();
    chk("rst_rvalid", 64'(if1.rvalid_o), 64'h0);
    next_cycle();
    settle();
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      rst = 1'b0;
      settle();
      chk("post_rst_rvalid", 64'(if3.rvalid_o), 64'h0);
    end

    // Lock held by port0 while both request
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      drv(2'b11, 2'b01, 2'b00, 64'h700 + 64'(i * 8), 64'h780);
      settle();
`ifdef MEM_ARB_LOCK_EN
      exp_g = 2'b01;
`else
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
      chk("lock_gnt", 64'(if1.gnt_o), 64'(exp_g));
    end
    next_cycle();
    drv(2'b11, 2'b00, 2'b00, 64'h740, 64'h780);
    settle();
`ifdef MEM_ARB_LOCK_EN
    chk("unlock_gnt", 64'(if1.gnt_o), 64'h2);
`else
    chk("unlock_gnt", 64'(if1.gnt_o), 64'h1);
`endif

    // Locked owner not requesting: other ports stay blocked
    next_cycle(); drv(2'b01, 2'b01, 2'b00, 64'h800, 64'h0); settle();
    next_cycle(); drv(2'b10, 2'b01, 2'b00, 64'h0, 64'h810); settle();
`ifdef MEM_ARB_LOCK_EN
    chk("lock_idle_gnt", 64'(if1.gnt_o), 64'h0);
`else
    chk("lock_idle_gnt", 64'(if1.gnt_o), 64'h2);
`endif
    next_cycle(); drv(2'b10, 2'b00, 2'b00, 64'h0, 64'h820); settle();
    chk("after_lock_gnt", 64'(if1.gnt_o), 64'h2);

    repeat (4) begin
      next_cycle();
      drv(2'b00, 2'b00, 2'b00, 64'h0, 64'h0);
      settle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
